// File: rtl/time_set_ctrl.sv
// Button front end and mode controller for a settable clock: synchronizes and
// debounces four buttons, steps the set mode, and issues adjust pulses with auto-repeat.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE     = 1_000_000,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter int unsigned TIMEOUT      = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_run,
  output logic [1:0] mode,
  output logic       plus,
  output logic       minus,
  output logic       enable
);

  localparam int unsigned NB     = 4;
  localparam int unsigned B_MODE = 0;
  localparam int unsigned B_UP   = 1;
  localparam int unsigned B_DN   = 2;
  localparam int unsigned B_RUN  = 3;

  localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned RP_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE - 1);
  localparam logic [RP_W-1:0] RP_MAX    = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_RELOAD =
    RP_W'((REPEAT_DELAY > REPEAT_RATE) ? (REPEAT_DELAY - REPEAT_RATE) : 0);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_S = 2'b01,
    SET_M = 2'b10,
    SET_H = 2'b11
  } state_e;

  logic [NB-1:0]   raw_c;
  logic [NB-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0]   db_q, db_d, dbp_q, dbp_d;
  logic [DB_W-1:0] cnt_q [NB];
  logic [DB_W-1:0] cnt_d [NB];

  state_e          state_q, state_d;
  logic            enable_q, enable_d;
  logic            plus_q, plus_d, minus_q, minus_d;
  logic            arm_q, arm_d;
  logic [RP_W-1:0] rep_q, rep_d;
  logic [TO_W-1:0] idle_q, idle_d;

  logic [NB-1:0]   rise_c, chg_c;
  logic            in_set_c, timeout_c, hold_up_c, hold_dn_c, pulse_ok_c;

  assign raw_c = {btn_run, btn_down, btn_up, btn_mode};

  // Synchronizer, debouncer and edge-history stages per button
  always_comb begin
    sync1_d = raw_c;
    sync2_d = sync1_q;
    dbp_d   = db_q;
    db_d    = db_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] >= DB_MAX) db_d[i] = sync2_q[i];
        else                    cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  assign rise_c    = db_q & ~dbp_q;
  assign chg_c     = db_q ^ dbp_q;
  assign in_set_c  = (state_q != RUN);
  assign timeout_c = in_set_c && (idle_q >= TO_MAX);
  assign hold_up_c = db_q[B_UP] & ~db_q[B_DN];
  assign hold_dn_c = db_q[B_DN] & ~db_q[B_UP];
  assign pulse_ok_c = in_set_c && !timeout_c && !rise_c[B_MODE];

  // Mode sequencing and run flag; timeout beats a coincident button event
  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    if (timeout_c) begin
      state_d  = RUN;
      enable_d = 1'b1;
    end else if (rise_c[B_MODE]) begin
      case (state_q)
        RUN: begin
          state_d  = SET_S;
          enable_d = 1'b0;
        end
        SET_S:   state_d = SET_M;
        SET_M:   state_d = SET_H;
        default: begin
          state_d  = RUN;
          enable_d = 1'b1;
        end
      endcase
    end else if (!in_set_c && rise_c[B_RUN]) begin
      enable_d = ~enable_q;
    end
  end

  // Idle timer restarts on any debounced activity or mode change
  always_comb begin
    idle_d = idle_q;
    if ((chg_c != '0) || (state_d != state_q)) idle_d = '0;
    else if (idle_q < TO_MAX)                  idle_d = idle_q + TO_W'(1);
  end

  // Adjust pulses: initial pulse on the event, then repeats while one button is held alone
  always_comb begin
    plus_d  = 1'b0;
    minus_d = 1'b0;
    rep_d   = rep_q;
    arm_d   = arm_q;
    if (!pulse_ok_c || !(hold_up_c || hold_dn_c)) begin
      rep_d = '0;
      arm_d = 1'b0;
    end else if (rise_c[B_UP] || rise_c[B_DN]) begin
      plus_d  = hold_up_c;
      minus_d = hold_dn_c;
      rep_d   = '0;
      arm_d   = 1'b1;
    end else if (arm_q) begin
      if (rep_q >= RP_MAX) begin
        plus_d  = hold_up_c;
        minus_d = hold_dn_c;
        rep_d   = RP_RELOAD;
      end else begin
        rep_d = rep_q + RP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      dbp_q    <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      state_q  <= RUN;
      enable_q <= 1'b1;
      plus_q   <= 1'b0;
      minus_q  <= 1'b0;
      arm_q    <= 1'b0;
      rep_q    <= '0;
      idle_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      dbp_q    <= dbp_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      state_q  <= state_d;
      enable_q <= enable_d;
      plus_q   <= plus_d;
      minus_q  <= minus_d;
      arm_q    <= arm_d;
      rep_q    <= rep_d;
      idle_q   <= idle_d;
    end
  end

  assign mode   = state_q;
  assign plus   = plus_q;
  assign minus  = minus_q;
  assign enable = enable_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce/repeat/timeout parameters.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_run = 1'b0;
  logic [1:0] mode;
  logic       plus, minus, enable;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .DEBOUNCE    (4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (5),
    .TIMEOUT     (100)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_mode(btn_mode),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .btn_run (btn_run),
    .mode    (mode),
    .plus    (plus),
    .minus   (minus),
    .enable  (enable)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mask bits: 0 mode, 1 up, 2 down, 3 run
  task automatic set_btns(input logic [3:0] mask);
    btn_mode = mask[0];
    btn_up   = mask[1];
    btn_down = mask[2];
    btn_run  = mask[3];
  endtask

  task automatic press(input logic [3:0] mask);
    set_btns(mask);
    tick(10);
    set_btns(4'b0000);
    tick(10);
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b0;
    tick(3);
    chk_cnt++; if (mode !== 2'b00) $display("FAIL reset_mode: got %b want 00", mode); else pass_cnt++;
    chk_cnt++; if (enable !== 1'b1) $display("FAIL reset_enable: got %b want 1", enable); else pass_cnt++;
    chk_cnt++; if (plus !== 1'b0) $display("FAIL reset_plus: got %b want 0", plus); else pass_cnt++;
    chk_cnt++; if (minus !== 1'b0) $display("FAIL reset_minus: got %b want 0", minus); else pass_cnt++;
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (mode !== 2'b00 || enable !== 1'b1 || plus !== 1'b0 || minus !== 1'b0) bad++;
    end
    chk_cnt++; if (bad !== 0) $display("FAIL idle_200: got %0d bad cycles want 0", bad); else pass_cnt++;
  endtask

  task automatic test_reset_held;
    reset = 1'b0;
    set_btns(4'b1000);
    tick(3);
    reset = 1'b1;
    tick(6);
    chk_cnt++; if (enable !== 1'b1) $display("FAIL held_through_reset_early: got %b want 1", enable); else pass_cnt++;
    tick(1);
    chk_cnt++; if (enable !== 1'b0) $display("FAIL held_through_reset_event: got %b want 0", enable); else pass_cnt++;
    set_btns(4'b0000);
    tick(10);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_run_glitch;
    set_btns(4'b1000);
    tick(3);
    set_btns(4'b0000);
    tick(15);
    chk_cnt++; if (enable !== 1'b1) $display("FAIL run_glitch: got %b want 1", enable); else pass_cnt++;
    set_btns(4'b1000);
    tick(6);
    chk_cnt++; if (enable !== 1'b1) $display("FAIL run_press_latency: got %b want 1", enable); else pass_cnt++;
    tick(1);
    chk_cnt++; if (enable !== 1'b0) $display("FAIL run_toggle_off: got %b want 0", enable); else pass_cnt++;
    tick(3);
    set_btns(4'b0000);
    tick(10);
    press(4'b1000);
    chk_cnt++; if (enable !== 1'b1) $display("FAIL run_toggle_on: got %b want 1", enable); else pass_cnt++;
  endtask

  task automatic test_mode_cycle;
    logic [1:0] exp_mode [4];
    logic       exp_en   [4];
    exp_mode = '{2'b01, 2'b10, 2'b11, 2'b00};
    exp_en   = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      press(4'b0001);
      chk_cnt++; if (mode !== exp_mode[i]) $display("FAIL mode_step%0d: got %b want %b", i, mode, exp_mode[i]); else pass_cnt++;
      chk_cnt++; if (enable !== exp_en[i]) $display("FAIL mode_enable%0d: got %b want %b", i, enable, exp_en[i]); else pass_cnt++;
    end
  endtask

  task automatic test_repeat;
    int          lat;
    logic [59:0] pv, expv;
    logic        minus_seen;
    press(4'b0001);
    chk_cnt++; if (mode !== 2'b01) $display("FAIL repeat_enter_sets: got %b want 01", mode); else pass_cnt++;
    expv = '0;
    expv[0] = 1'b1;
    for (int o = 20; o < 60; o += 5) expv[o] = 1'b1;
    set_btns(4'b0010);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (plus === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk_cnt++; if (lat !== 7) $display("FAIL up_event_latency: got %0d want 7", lat); else pass_cnt++;
    pv = '0;
    pv[0] = plus;
    minus_seen = minus;
    for (int o = 1; o < 60; o++) begin
      tick(1);
      pv[o] = plus;
      minus_seen = minus_seen | minus;
    end
    chk_cnt++; if (pv !== expv) $display("FAIL repeat_pattern: got %h want %h", pv, expv); else pass_cnt++;
    chk_cnt++; if (minus_seen !== 1'b0) $display("FAIL repeat_minus: got %b want 0", minus_seen); else pass_cnt++;
    set_btns(4'b0000);
    tick(12);
  endtask

  task automatic test_both;
    logic any_pulse;
    logic minus_seen;
    press(4'b0001);
    chk_cnt++; if (mode !== 2'b10) $display("FAIL both_enter_setm: got %b want 10", mode); else pass_cnt++;
    any_pulse = 1'b0;
    set_btns(4'b0110);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      any_pulse = any_pulse | plus | minus;
    end
    set_btns(4'b0010);
    for (int i = 0; i < 30; i++) begin
      tick(1);
      any_pulse = any_pulse | plus | minus;
    end
    set_btns(4'b0000);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      any_pulse = any_pulse | plus | minus;
    end
    chk_cnt++; if (any_pulse !== 1'b0) $display("FAIL both_held_pulse: got %b want 0", any_pulse); else pass_cnt++;
    minus_seen = 1'b0;
    set_btns(4'b0101);
    for (int i = 0; i < 30; i++) begin
      tick(1);
      minus_seen = minus_seen | minus | plus;
    end
    set_btns(4'b0000);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      minus_seen = minus_seen | minus | plus;
    end
    chk_cnt++; if (mode !== 2'b11) $display("FAIL mode_down_same_cycle_mode: got %b want 11", mode); else pass_cnt++;
    chk_cnt++; if (minus_seen !== 1'b0) $display("FAIL mode_down_same_cycle_pulse: got %b want 0", minus_seen); else pass_cnt++;
  endtask

  task automatic test_timeout;
    tick(80);
    chk_cnt++; if (mode !== 2'b11) $display("FAIL timeout_early_mode: got %b want 11", mode); else pass_cnt++;
    chk_cnt++; if (enable !== 1'b0) $display("FAIL timeout_early_enable: got %b want 0", enable); else pass_cnt++;
    tick(40);
    chk_cnt++; if (mode !== 2'b00) $display("FAIL timeout_mode: got %b want 00", mode); else pass_cnt++;
    chk_cnt++; if (enable !== 1'b1) $display("FAIL timeout_enable: got %b want 1", enable); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic first_seen, rep_seen;
    press(4'b0001);
    set_btns(4'b0010);
    first_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (plus === 1'b1) begin
        first_seen = 1'b1;
        break;
      end
    end
    rep_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (plus === 1'b1) begin
        rep_seen = 1'b1;
        break;
      end
    end
    chk_cnt++; if ((first_seen & rep_seen) !== 1'b1) $display("FAIL mid_repeat_reached: got %b%b want 11", first_seen, rep_seen); else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    chk_cnt++; if (plus !== 1'b0) $display("FAIL reset_abort_plus: got %b want 0", plus); else pass_cnt++;
    chk_cnt++; if (mode !== 2'b00) $display("FAIL reset_abort_mode: got %b want 00", mode); else pass_cnt++;
    chk_cnt++; if (enable !== 1'b1) $display("FAIL reset_abort_enable: got %b want 1", enable); else pass_cnt++;
    set_btns(4'b0000);
    tick(2);
    reset = 1'b1;
    tick(10);
    chk_cnt++; if (mode !== 2'b00 || plus !== 1'b0) $display("FAIL after_reset_state: got mode %b plus %b want 00 0", mode, plus); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_reset_held;
    test_run_glitch;
    test_mode_cycle;
    test_repeat;
    test_both;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
